// File: rtl/sr_latch_checker.sv
`default_nettype none
// ============================================================================
// sr_latch_checker: sweeps S/R vectors into a latch and checks Q/Q_ vs NOR model
// Revision 1.0
// ============================================================================
module sr_latch_checker #(
  parameter int SETTLE = 4,
  parameter int ROUNDS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q,
  input  logic       q_n,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       mismatch,
  output logic [7:0] err_cnt,
  output logic [7:0] check_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [5:0] c_ROUND_LAST  = 6'(ROUNDS - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_settle_cnt;
  logic [1:0] r_vec;
  logic [5:0] r_round;
  logic       r_model_q;
  logic       r_model_qn;
  logic       r_model_known;
  logic [7:0] r_err_cnt;
  logic [7:0] r_check_cnt;
  logic       r_mismatch;

  logic       w_start_run;
  logic       w_last_vec;
  logic       w_cmp_en;
  logic       w_exp_q;
  logic       w_exp_qn;
  logic       w_fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    w_last_vec  = (r_vec == 2'd3) && (r_round == c_ROUND_LAST);
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = DRIVE;
          w_start_run = 1'b1;
        end
      end
      DRIVE: begin
        if (r_settle_cnt == c_SETTLE_LAST) begin
          w_state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        w_state_nxt = w_last_vec ? DONE : DRIVE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // 00 holds the previous state, so it is only checkable once a 01/10 set it
  always_comb begin
    w_cmp_en = 1'b1;
    w_exp_q  = 1'b0;
    w_exp_qn = 1'b0;
    case (r_vec)
      2'b00: begin
        w_cmp_en = r_model_known;
        w_exp_q  = r_model_q;
        w_exp_qn = r_model_qn;
      end
      2'b01: w_exp_qn = 1'b1;
      2'b10: w_exp_q  = 1'b1;
      default: begin
        w_exp_q  = 1'b0;
        w_exp_qn = 1'b0;
      end
    endcase
    w_fail = w_cmp_en && ((q != w_exp_q) || (q_n != w_exp_qn));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle_cnt  <= 8'd0;
      r_vec         <= 2'd0;
      r_round       <= 6'd0;
      r_model_q     <= 1'b0;
      r_model_qn    <= 1'b0;
      r_model_known <= 1'b0;
      r_err_cnt     <= 8'd0;
      r_check_cnt   <= 8'd0;
      r_mismatch    <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      if (w_start_run) begin
        r_settle_cnt  <= 8'd0;
        r_vec         <= 2'd0;
        r_round       <= 6'd0;
        r_model_known <= 1'b0;
        r_err_cnt     <= 8'd0;
        r_check_cnt   <= 8'd0;
      end else if (r_state == DRIVE) begin
        r_settle_cnt <= r_settle_cnt + 8'd1;
      end else if (r_state == SAMPLE) begin
        r_settle_cnt <= 8'd0;
        r_vec        <= r_vec + 2'd1;
        if (r_vec == 2'd3) begin
          r_round <= r_round + 6'd1;
        end
        if (w_cmp_en) begin
          r_check_cnt <= r_check_cnt + 8'd1;
          if (w_fail) begin
            r_mismatch <= 1'b1;
            if (r_err_cnt != 8'hFF) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
          end
        end
        case (r_vec)
          2'b01: begin
            r_model_known <= 1'b1;
            r_model_q     <= 1'b0;
            r_model_qn    <= 1'b1;
          end
          2'b10: begin
            r_model_known <= 1'b1;
            r_model_q     <= 1'b1;
            r_model_qn    <= 1'b0;
          end
          2'b11: r_model_known <= 1'b0;
          default: r_model_known <= r_model_known;
        endcase
      end
    end
  end

  assign busy      = (r_state == DRIVE) || (r_state == SAMPLE);
  assign done      = (r_state == DONE);
  assign pass      = done && (r_err_cnt == 8'd0);
  assign s         = busy & r_vec[1];
  assign r         = busy & r_vec[0];
  assign mismatch  = r_mismatch;
  assign err_cnt   = r_err_cnt;
  assign check_cnt = r_check_cnt;

endmodule
`default_nettype wire

// File: doc/sr_latch_checker.md
SR_LATCH_CHECKER -- requirements
Module: sr_latch_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 4: cycles each S/R vector is held before Q/Q_ are sampled; legal range 1..255.
REQ-002 SHALL have parameter ROUNDS, default 5: passes through the 4-vector sequence per run; legal range 1..63.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begins a run when sampled high in IDLE or DONE.
REQ-006 SHALL have port q  input  1  Q output of the latch under test.
REQ-007 SHALL have port q_n  input  1  Q_ output of the latch under test.
REQ-008 SHALL have port s  output  1  S drive to the latch under test.
REQ-009 SHALL have port r  output  1  R drive to the latch under test.
REQ-010 SHALL have port busy  output  1  high in DRIVE or SAMPLE.
REQ-011 SHALL have port done  output  1  high in DONE.
REQ-012 SHALL have port pass  output  1  done and err_cnt==0.
REQ-013 SHALL have port mismatch  output  1  one-cycle pulse per failed compare.
REQ-014 SHALL have port err_cnt  output  8  failed compares, saturating at 255.
REQ-015 SHALL have port check_cnt  output  8  compares performed, excluding skipped vectors.

Function
REQ-016 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE, all registered on clk.
REQ-017 SHALL apply the vector sequence {s,r} = 00, 01, 10, 11, repeated ROUNDS times, for a total of 4*ROUNDS vectors.
REQ-018 SHALL move IDLE -> DRIVE on start; vector 0 is driven on s/r in the first DRIVE cycle; err_cnt, check_cnt and the model are cleared on the same edge.
REQ-019 SHALL hold DRIVE for exactly SETTLE cycles, then spend 1 cycle in SAMPLE, with s/r constant across DRIVE and SAMPLE (SETTLE+1 cycles per vector).
REQ-020 SHALL compare the q/q_n values present during the SAMPLE cycle on the edge that leaves SAMPLE.
REQ-021 SHALL leave SAMPLE for DRIVE with the next vector, or for DONE after the last vector.
REQ-022 SHALL drive s=r=0 in IDLE and DONE.
REQ-023 SHALL use this expected-value model (NOR latch): 01 -> q=0,q_n=1; 10 -> q=1,q_n=0; 11 -> q=0,q_n=0; 00 -> hold the previous expected state.
REQ-024 SHALL mark the model state unknown after reset, at run start, and after any 11 vector.
REQ-025 SHALL skip the compare for a 00 vector with unknown model state: no check_cnt increment, no error.
REQ-026 SHALL restore the model state to known on the next 01 or 10 vector.
REQ-027 SHALL, on each performed compare, increment check_cnt; on a mismatch of either bit it SHALL also increment err_cnt (saturating) and raise mismatch for the following cycle only.
REQ-028 SHALL yield, at default parameters, 15 compares (3 per round), 5 skips, and a run length of 100 cycles from the first DRIVE cycle to DONE entry.
REQ-029 SHALL ignore start while busy.
REQ-030 SHALL restart a run when start is asserted in DONE, exactly as from IDLE; done and pass drop on that edge.
REQ-031 SHALL hold err_cnt, check_cnt and pass stable in DONE until the next start or reset.

Reset
REQ-032 SHALL, when rst is high at a clk edge, enter IDLE and set s=0, r=0, busy=0, done=0, pass=0, mismatch=0, err_cnt=0 and check_cnt=0, and clear internal counters; this applies in every state, including mid-run.
REQ-033 SHALL give rst priority over start when both are high on the same edge.

Verification
REQ-034 SHALL be verified with an ideal NOR latch model connected and start pulsed at defaults: DONE reached 100 cycles after the first DRIVE cycle, pass=1, err_cnt=0, check_cnt=15, mismatch never high.
REQ-035 SHALL be verified with q stuck at 0: err_cnt=5 (one per 10 vector), check_cnt=15, pass=0, and 5 mismatch pulses.
REQ-036 SHALL be verified with q_n forced to ~q: each 11 vector fails, giving err_cnt=5 and pass=0.
REQ-037 SHALL be verified with rst asserted for one cycle 40 cycles into a run: on the next cycle busy=0, s=r=0 and err_cnt=0; a fresh start then completes with pass=1.
REQ-038 SHALL be verified with start pulsed repeatedly during a run: the run length stays 100 cycles; start in DONE restarts with counters cleared.
REQ-039 SHALL be verified with SETTLE=1 and ROUNDS=2: run length 16 cycles, check_cnt=6.
